operand_fetch: RTL

//  Decode/operand stage directly upstream of the ALU in the Harvard 5-instruction core.

---
 rtl/operand_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Decode/operand stage: 32-entry GPR file, instruction decode, one registered output slot.
// Latency 1 cycle from accept; in_ready = !out_valid || out_ready, so a stalled slot holds exactly.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [5:0]        ALUOp,
  output logic [5:0]        func_code,
  output logic [REG_AW-1:0] dest_reg,
  output logic              dest_we,
  output logic [DATA_W-1:0] register_v0
);

  localparam int         NREG     = 1 << REG_AW;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] FN_ADDU  = 6'b100001;

  logic [DATA_W-1:0] gpr_q [NREG];

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [15:0]       imm16;
  logic [5:0]        funct;
  logic              is_rtype;

  assign opcode   = instr[31:26];
  assign rs_addr  = instr[25:21];
  assign rt_addr  = instr[20:16];
  assign rd_addr  = instr[15:11];
  assign imm16    = instr[15:0];
  assign funct    = instr[5:0];
  assign is_rtype = (opcode == OP_RTYPE);

  // Register reads see a writeback landing in the same cycle.
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  always_comb begin
    rs_val = gpr_q[rs_addr];
    if (rs_addr == '0) begin
      rs_val = '0;
    end else if (wb_en && (wb_addr == rs_addr)) begin
      rs_val = wb_data;
    end
  end

  always_comb begin
    rt_val = gpr_q[rt_addr];
    if (rt_addr == '0) begin
      rt_val = '0;
    end else if (wb_en && (wb_addr == rt_addr)) begin
      rt_val = wb_data;
    end
  end

  logic [DATA_W-1:0] dec_op2;
  logic [5:0]        dec_func;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_we;

  always_comb begin
    dec_op2  = {{(DATA_W-16){imm16[15]}}, imm16};
    dec_func = 6'b0;
    dec_dest = rt_addr;
    dec_we   = (opcode == OP_ADDIU);
    if (is_rtype) begin
      dec_op2  = rt_val;
      dec_func = funct;
      dec_dest = rd_addr;
      dec_we   = (funct == FN_ADDU);
    end
    if (dec_dest == '0) begin
      dec_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      gpr_q[wb_addr] <= wb_data;
    end
  end

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [5:0]        aluop_q, aluop_d;
  logic [5:0]        func_q, func_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              dest_we_q, dest_we_d;
  logic              accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    aluop_d   = aluop_q;
    func_d    = func_q;
    dest_d    = dest_q;
    dest_we_d = dest_we_q;
    if (accept) begin
      valid_d   = 1'b1;
      op1_d     = rs_val;
      op2_d     = dec_op2;
      aluop_d   = opcode;
      func_d    = dec_func;
      dest_d    = dec_dest;
      dest_we_d = dec_we;
    end else if (out_ready) begin
      // Data fields deliberately hold after the slot drains.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= '0;
      func_q    <= '0;
      dest_q    <= '0;
      dest_we_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      aluop_q   <= aluop_d;
      func_q    <= func_d;
      dest_q    <= dest_d;
      dest_we_q <= dest_we_d;
    end
  end

  assign out_valid   = valid_q;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign ALUOp       = aluop_q;
  assign func_code   = func_q;
  assign dest_reg    = dest_q;
  assign dest_we     = dest_we_q;
  assign register_v0 = gpr_q[2];

endmodule
